// File: rtl/phoneme_queue.sv
// Host-to-chatter phoneme FIFO with a write/busy handshake FSM and an ack-timeout flag.
// Optional: define PHONEME_QUEUE_AUTOPAUSE_EN to append a PA4 (6'h03) after each utterance.
module phoneme_queue #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [5:0]        data,
  output logic              write,
  input  logic              busy,
  output logic [ADDR_W:0]   count,
  output logic              idle,
  output logic              ack_err
);

  localparam logic [1:0]        S_IDLE   = 2'd0;
  localparam logic [1:0]        S_ACK    = 2'd1;
  localparam logic [1:0]        S_PLAY   = 2'd2;
  localparam logic [ADDR_W:0]   FULL     = (ADDR_W+1)'(DEPTH);
  localparam logic [7:0]        ACK_LAST = 8'(ACK_TIMEOUT - 1);

  logic [5:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [1:0]        state_q, state_d;
  logic [7:0]        timer_q, timer_d;
  logic [5:0]        data_q, data_d;
  logic              write_q, write_d;
  logic              ack_err_q, ack_err_d;
  logic              pop, push;
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
  localparam logic [5:0] PAUSE_CODE = 6'h03;
  logic arm_q, arm_d, pend_q, pend_d;
`endif

  // A pop frees a slot, so a push is accepted at full when it coincides with a pop.
  assign pop  = (state_q == S_IDLE) && (count_q != '0) && !busy && !flush;
  assign push = in_valid && !flush && ((count_q != FULL) || pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    data_d    = data_q;
    write_d   = 1'b0;
    ack_err_d = ack_err_q;
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
    arm_d  = arm_q;
    pend_d = pend_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          data_d  = mem_q[rd_ptr_q];
          write_d = 1'b1;
          timer_d = '0;
          state_d = S_ACK;
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
          arm_d  = (mem_q[rd_ptr_q] > 6'd4);
          pend_d = 1'b0;
        end else if (push) begin
          pend_d = 1'b0;
        end else if (pend_q && !busy && !flush) begin
          data_d  = PAUSE_CODE;
          write_d = 1'b1;
          timer_d = '0;
          state_d = S_ACK;
          arm_d   = 1'b0;
          pend_d  = 1'b0;
`endif
        end
      end
      S_ACK: begin
        if (busy) begin
          state_d = S_PLAY;
        end else if (timer_q == ACK_LAST) begin
          ack_err_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      S_PLAY: begin
        if (!busy) begin
          state_d = S_IDLE;
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
          pend_d = arm_q && (count_q == '0) && !push;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
    if (flush) begin
      arm_d  = 1'b0;
      pend_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      state_q   <= S_IDLE;
      timer_q   <= '0;
      data_q    <= '0;
      write_q   <= 1'b0;
      ack_err_q <= 1'b0;
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
      arm_q  <= 1'b0;
      pend_q <= 1'b0;
`endif
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      state_q   <= state_d;
      timer_q   <= timer_d;
      data_q    <= data_d;
      write_q   <= write_d;
      ack_err_q <= ack_err_d;
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
      arm_q  <= arm_d;
      pend_q <= pend_d;
`endif
    end
  end

  assign in_ready = (count_q != FULL);
  assign data     = data_q;
  assign write    = write_q;
  assign count    = count_q;
  assign ack_err  = ack_err_q;
  assign idle     = (count_q == '0) && (state_q == S_IDLE) && !busy;

endmodule

// File: tb/tb_phoneme_queue.sv
// Directed bench for phoneme_queue with a small chatter model (busy rises 2 cycles after write).
module tb_phoneme_queue;

  localparam int unsigned PLAY = 4;

  logic       clk = 1'b0;
  logic       rst, in_valid, flush, busy_man, chat_en;
  logic [5:0] in_data;
  logic       in_ready, write, idle, ack_err, busy;
  logic [5:0] data;
  logic [4:0] count;

  logic       mb = 1'b0, mpend = 1'b0;
  int         mleft = 0;
  logic       busy_prev = 1'b0, write_prev = 1'b0;
  int         gap_bad = 0, consec_bad = 0;
  logic [5:0] wlog [$];
  int         nvec = 0, nfail = 0;

  phoneme_queue #(.DEPTH(16), .ADDR_W(4), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .data(data), .write(write), .busy(busy), .count(count),
    .idle(idle), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  assign busy = chat_en ? mb : busy_man;

  always @(posedge clk) begin
    if (!chat_en) begin
      mb <= 1'b0; mpend <= 1'b0; mleft <= 0;
    end else begin
      mpend <= write;
      if (mpend) begin
        mb <= 1'b1; mleft <= PLAY - 1;
      end else if (mleft != 0) mleft <= mleft - 1;
      else mb <= 1'b0;
    end
  end

  // Every write must see busy low on this and the previous sample.
  always @(posedge clk) begin
    if (write === 1'b1) begin
      wlog.push_back(data);
      if (busy || busy_prev) gap_bad++;
      if (write_prev) consec_bad++;
    end
    write_prev <= write;
    busy_prev  <= busy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_n(2);
    rst = 1'b0;
    wlog.delete();
  endtask

  function automatic logic [5:0] logat(input int i);
    return (i < wlog.size()) ? wlog[i] : 6'h3F;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_data = '0; busy_man = 1'b0; chat_en = 1'b1;
    @(negedge clk);
    do_reset();
    chk("rst_write", write, 0);
    chk("rst_data", data, 0);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ack_err", ack_err, 0);
    chk("rst_idle", idle, 1);

    // single phoneme
    in_valid = 1'b1; in_data = 6'h07;
    cyc_n(1);
    in_valid = 1'b0;
    chk("t1_count_after_push", count, 1);
    chk("t1_no_write_yet", write, 0);
    cyc_n(1);
    chk("t1_write", write, 1);
    chk("t1_data", data, 6'h07);
    cyc_n(30);
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
    chk("t1_nwrites", wlog.size(), 2);
    chk("t1_pause", logat(1), 6'h03);
`else
    chk("t1_nwrites", wlog.size(), 1);
`endif
    chk("t1_log0", logat(0), 6'h07);
    chk("t1_idle", idle, 1);

    // back-to-back phonemes
    wlog.delete();
    in_valid = 1'b1; in_data = 6'h05; cyc_n(1);
    in_data = 6'h06; cyc_n(1);
    in_data = 6'h07; cyc_n(1);
    in_valid = 1'b0;
    chk("t2_count_mid", count, 2);
    cyc_n(60);
`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
    chk("t2_nwrites", wlog.size(), 4);
    chk("t2_pause", logat(3), 6'h03);
`else
    chk("t2_nwrites", wlog.size(), 3);
`endif
    chk("t2_log0", logat(0), 6'h05);
    chk("t2_log1", logat(1), 6'h06);
    chk("t2_log2", logat(2), 6'h07);
    chk("t2_count_end", count, 0);

    // fill to full with busy held high
    chat_en = 1'b0; busy_man = 1'b1;
    for (int i = 0; i < 17; i++) begin
      in_valid = 1'b1; in_data = 6'h20 + 6'(i);
      cyc_n(1);
      if (i == 15) chk("t3_ready_at_16", in_ready, 0);
    end
    in_valid = 1'b0;
    chk("t3_count_full", count, 16);
    chk("t3_ready_full", in_ready, 0);
    busy_man = 1'b0; in_valid = 1'b1; in_data = 6'h3A;
    cyc_n(1);
    in_valid = 1'b0;
    chk("t3_count_pushpop", count, 16);
    chk("t3_write", write, 1);
    chk("t3_head", data, 6'h20);
    do_reset();

    // ack timeout: busy never rises
    in_valid = 1'b1; in_data = 6'h11; cyc_n(1);
    in_data = 6'h12; cyc_n(1);
    in_valid = 1'b0;
    chk("t4_write", write, 1);
    chk("t4_data", data, 6'h11);
    cyc_n(7);
    chk("t4_no_err_early", ack_err, 0);
    cyc_n(1);
    chk("t4_err", ack_err, 1);
    chk("t4_write_low", write, 0);
    cyc_n(1);
    chk("t4_next_write", write, 1);
    chk("t4_next_data", data, 6'h12);
    cyc_n(20);
    chk("t4_err_sticky", ack_err, 1);
    do_reset();
    chk("t4_err_cleared", ack_err, 0);

    // flush while playing
    chat_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      in_valid = 1'b1; in_data = 6'h08 + 6'(i);
      cyc_n(1);
    end
    in_valid = 1'b0;
    chk("t5_count_queued", count, 5);
    flush = 1'b1; cyc_n(1); flush = 1'b0;
    chk("t5_count_flushed", count, 0);
    cyc_n(30);
    chk("t5_nwrites", wlog.size(), 1);
    chk("t5_log0", logat(0), 6'h08);
    chk("t5_idle", idle, 1);

`ifdef PHONEME_QUEUE_AUTOPAUSE_EN
    do_reset();
    in_valid = 1'b1; in_data = 6'h13; cyc_n(1); in_valid = 1'b0;
    cyc_n(40);
    chk("t6_nwrites", wlog.size(), 2);
    chk("t6_log0", logat(0), 6'h13);
    chk("t6_log1", logat(1), 6'h03);
    wlog.delete();
    in_valid = 1'b1; in_data = 6'h02; cyc_n(1); in_valid = 1'b0;
    cyc_n(30);
    chk("t6_pause_only", wlog.size(), 1);
    chk("t6_pause_code", logat(0), 6'h02);
    wlog.delete();
    in_valid = 1'b1; in_data = 6'h15; cyc_n(1); in_valid = 1'b0;
    cyc_n(4);
    rst = 1'b1; cyc_n(1);
    chk("t6_rst_write", write, 0);
    chk("t6_rst_count", count, 0);
    rst = 1'b0;
    cyc_n(30);
    chk("t6_rst_nwrites", wlog.size(), 1);
    chk("t6_rst_idle", idle, 1);
`endif

    chk("gap_violations", gap_bad, 0);
    chk("consec_writes", consec_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
